thumb_encoder: RTL and testbench
================================

# thumb_encoder

Assembles 16-bit Thumb instruction words from a format code plus operand fields and queues them for the instruction-memory loader. It is the inverse of the decode-stage `control` block. Its `fmt` input uses the same format-select codes that `control` emits, so a word this block builds decodes back to the same `fmt`. A 4-entry FIFO with valid/ready handshakes sits between the encoder and the loader. Unsupported or illegal format/op combinations are dropped and counted.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of 2.
- `clk` input 1: the only clock. Everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request carries a valid instruction description.
- `in_ready` output 1: block can accept a request this cycle.
- `fmt` input 6: format select code (listed under Operation).
- `op` input 4: format-specific opcode/flag bits.
- `rd` input 3: destination register.
- `rs` input 3: source or base register (Rs/Rb).
- `rn` input 3: Rn, Ro, or off3.
- `imm` input 11: immediate. Truncated to the field width of the format.
- `out_valid` output 1: `out_instr` holds a queued word.
- `out_ready` input 1: loader takes the word this cycle.
- `out_instr` output 16: head-of-queue instruction word.
- `err_fmt` output 1: one-cycle pulse when an accepted request is dropped.
- `err_count` output 8: number of dropped requests. Saturates at 255.
- `level` output 3: current FIFO occupancy, 0 to DEPTH.

## Operation
Encoding rules, listed as fmt: layout. Bits are MSB to LSB, and immediates use their low bits.
- 1: `000`, `op[1:0]`, `imm[4:0]`, `rs`, `rd`. `op[1:0]`=3 is illegal.
- 2: `00011`, `op[1:0]` (I, sub), `rn`, `rs`, `rd`.
- 3: `001`, `op[1:0]`, `rd`, `imm[7:0]`.
- 4: `010000`, `op[3:0]`, `rs`, `rd`.
- 6: `01001`, `rd`, `imm[7:0]`.
- 7: `0101`, `op[1]` (L), `op[0]` (B), `0`, `rn`, `rs`, `rd`.
- 9: `011`, `op[1]` (B), `op[0]` (L), `imm[4:0]`, `rs`, `rd`.
- 10: `1000`, `op[0]` (L), `imm[4:0]`, `rs`, `rd`.
- 11: `1001`, `op[0]` (L), `rd`, `imm[7:0]`.
- 12: `1010`, `op[0]` (SP), `rd`, `imm[7:0]`.
- 16: `1101`, `op[3:0]` (cond), `imm[7:0]`. cond 4'hE and 4'hF are illegal.
- 18: `11100`, `imm[10:0]`.
- Any other `fmt`, including 0, is illegal.

Behaviour:
- A request is accepted when `in_valid` and `in_ready` are both high.
- A legal request is written to `mem[wr_ptr]` and `wr_ptr` increments.
- An illegal request is accepted but not written. `err_fmt` pulses next cycle and `err_count` increments, saturating at 255.
- A pop occurs when `out_valid` and `out_ready` are both high. `rd_ptr` increments.
- Both pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `level` is updated as `level + push - pop`.
- `in_ready` = (`level` != DEPTH). It is registered-derived with no combinational path from `out_ready`.
- `out_valid` = (`level` != 0). `out_instr` = `mem[rd_ptr]`, read first-word-fall-through from registered storage.
- When `in_ready` is low, an illegal request is not accepted either and produces no error.

## Timing
Reset:
- While `rst_n` is low, all outputs are forced: `in_ready`=1, `out_valid`=0, `out_instr`=16'h0000, `err_fmt`=0, `err_count`=0, `level`=0.
- The pointers are also cleared. FIFO contents are don't-care.
- Reset asserted mid-stream discards every queued word immediately; nothing is emitted afterward.

Latency and throughput:
- A word accepted on edge N appears on `out_instr` with `out_valid`=1 after edge N if the FIFO was empty (one-cycle latency).
- Throughput is one word per cycle in steady state.
- Output ordering strictly follows acceptance order.

Boundary conditions:
- Push and pop in the same cycle: `level` is unchanged and both pointers advance. This is legal at any level from 1 to DEPTH-1. At DEPTH no push is possible.
- Full (`level`=DEPTH): `in_ready` goes low after the edge that filled the FIFO. It returns high after the edge of the first pop.
- Empty: `out_valid`=0 and `out_instr` holds its last value. `out_ready` is ignored.
- An illegal request accepted while the FIFO is empty leaves `out_valid` low.
- `err_fmt` is high only for the cycle after acceptance of an illegal request. Back-to-back illegal requests keep it high continuously.
- `err_count` holds at 255 once saturated.

## Test plan
- Encoding: `fmt`=3, `op`=0, `rd`=3, `imm`=11'h042 -> `out_instr`=16'h2342 one cycle after acceptance. `fmt`=4, `op`=4'hA, `rs`=2, `rd`=1 -> 16'h4291. `fmt`=18, `imm`=11'h7FF -> 16'hE7FF.
- Illegal requests: `fmt`=16 with `op`=4'hE, then `fmt`=1 with `op`=3, then `fmt`=5. Required: `out_valid` stays 0, `err_fmt` is high for 3 consecutive cycles, `err_count` reaches 3.
- Fill and drain: hold `out_ready`=0 and push 4 legal words. `in_ready`=0 and `level`=4, and a 5th request is not accepted. Then drain with `out_ready`=1: the 4 words emerge in order and `level` steps down 3, 2, 1, 0.
- Streaming at capacity: `in_valid`=1 and `out_ready`=1 for 20 cycles with 2 words preloaded. `level` stays 2 and all 22 words emerge in order across pointer wrap.
- Reset mid-operation: with 3 words queued, pulse `rst_n` low between edges. `out_valid` drops to 0 immediately and `level`=0. After release, a new word emerges at 1-cycle latency.
- Saturation: 260 illegal requests -> `err_count`=255.

Source files
------------

// File: rtl/thumb_encoder_if.sv
// Request/response bundle between an instruction producer, the Thumb encoder
// FIFO and the instruction-memory loader.
interface thumb_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  fmt;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rn;
    logic [10:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;

    modport master (
        output in_valid, fmt, op, rd, rs, rn, imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, fmt, op, rd, rs, rn, imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/thumb_encoder.sv
// Builds 16-bit Thumb words from format code + operand fields and queues them
// in a small first-word-fall-through FIFO; illegal requests are dropped and counted.
module thumb_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    thumb_encoder_if.slave           bus,
    output logic                     err_fmt,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic [15:0]   out_instr_reg;
    logic [15:0]   head_next;
    logic          err_fmt_reg;
    logic [7:0]    err_count_reg;
    logic [15:0]   word;
    logic          legal;
    logic          in_ready_int;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        word  = 16'h0000;
        legal = 1'b1;
        case (bus.fmt)
            6'd1: begin
                word  = {3'b000, bus.op[1:0], bus.imm[4:0], bus.rs, bus.rd};
                legal = (bus.op[1:0] != 2'b11);
            end
            6'd2:  word = {5'b00011, bus.op[1:0], bus.rn, bus.rs, bus.rd};
            6'd3:  word = {3'b001, bus.op[1:0], bus.rd, bus.imm[7:0]};
            6'd4:  word = {6'b010000, bus.op, bus.rs, bus.rd};
            6'd6:  word = {5'b01001, bus.rd, bus.imm[7:0]};
            6'd7:  word = {4'b0101, bus.op[1], bus.op[0], 1'b0, bus.rn, bus.rs, bus.rd};
            6'd9:  word = {3'b011, bus.op[1], bus.op[0], bus.imm[4:0], bus.rs, bus.rd};
            6'd10: word = {4'b1000, bus.op[0], bus.imm[4:0], bus.rs, bus.rd};
            6'd11: word = {4'b1001, bus.op[0], bus.rd, bus.imm[7:0]};
            6'd12: word = {4'b1010, bus.op[0], bus.rd, bus.imm[7:0]};
            6'd16: begin
                word  = {4'b1101, bus.op, bus.imm[7:0]};
                legal = (bus.op[3:1] != 3'b111);
            end
            6'd18: word = {5'b11100, bus.imm[10:0]};
            default: legal = 1'b0;
        endcase
    end

    assign in_ready_int = (level_reg != FULL);
    assign accept       = bus.in_valid && in_ready_int;
    assign push         = accept && legal;
    assign pop          = (level_reg != '0) && bus.out_ready;
    assign rd_ptr_next  = rd_ptr_reg + AW'(pop);
    assign level_next   = level_reg + LW'(push) - LW'(pop);

    // Head register tracks mem[rd_ptr]; a word pushed into an empty (or
    // emptying) queue bypasses storage so it shows up one cycle after acceptance.
    always_comb begin
        head_next = out_instr_reg;
        if (level_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next))
                head_next = word;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            out_instr_reg <= 16'h0000;
            err_fmt_reg   <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            wr_ptr_reg    <= wr_ptr_reg + AW'(push);
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            out_instr_reg <= head_next;
            err_fmt_reg   <= accept && !legal;
            if (accept && !legal && (err_count_reg != 8'hFF))
                err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (level_reg != '0);
    assign bus.out_instr = out_instr_reg;
    assign err_fmt       = err_fmt_reg;
    assign err_count     = err_count_reg;
    assign level         = level_reg;
endmodule

// File: tb/tb_thumb_encoder.sv
// Directed bench for thumb_encoder: encodings, illegal drops, fill/drain,
// streaming across wrap, mid-stream reset and error-counter saturation.
module tb_thumb_encoder;
    logic        clk;
    logic        rst_n;
    logic        err_fmt;
    logic [7:0]  err_count;
    logic [2:0]  level;
    int          checks;
    int          errors;
    logic [15:0] exp_q[$];

    thumb_encoder_if bus();

    thumb_encoder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_fmt   (err_fmt),
        .err_count (err_count),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [5:0] f, input logic [3:0] o, input logic [2:0] d,
                           input logic [2:0] s, input logic [2:0] n, input logic [10:0] i);
        bus.fmt      = f;
        bus.op       = o;
        bus.rd       = d;
        bus.rs       = s;
        bus.rn       = n;
        bus.imm      = i;
        bus.in_valid = 1'b1;
    endtask

    // One legal request into an empty FIFO, popped again right away.
    task automatic enc_case(input string tag, input logic [5:0] f, input logic [3:0] o,
                            input logic [2:0] d, input logic [2:0] s, input logic [2:0] n,
                            input logic [10:0] i, input logic [15:0] exp);
        set_req(f, o, d, s, n, i);
        tick;
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
        check(tag, bus.out_instr, exp);
        $display("enc %s fmt=%0d -> %h", tag, f, bus.out_instr);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check({tag, "_empty"}, 16'(bus.out_valid), 16'd0);
        check({tag, "_hold"}, bus.out_instr, exp);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fmt       = '0;
        bus.op        = '0;
        bus.rd        = '0;
        bus.rs        = '0;
        bus.rn        = '0;
        bus.imm       = '0;

        #2;
        check("rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_out_instr", bus.out_instr, 16'h0000);
        check("rst_err_fmt", 16'(err_fmt), 16'd0);
        check("rst_err_count", 16'(err_count), 16'd0);
        check("rst_level", 16'(level), 16'd0);
        tick;
        tick;
        rst_n = 1'b1;

        // Encodings: fmt, op, rd, rs, rn, imm -> expected word
        enc_case("f3",  6'd3,  4'h0, 3'd3, 3'd0, 3'd0, 11'h042, 16'h2342);
        enc_case("f4",  6'd4,  4'hA, 3'd1, 3'd2, 3'd0, 11'h000, 16'h4291);
        enc_case("f18", 6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h7FF, 16'hE7FF);
        enc_case("f1",  6'd1,  4'h1, 3'd7, 3'd2, 3'd0, 11'h01F, 16'h0FD7);
        enc_case("f2",  6'd2,  4'h2, 3'd4, 3'd3, 3'd5, 11'h000, 16'h1D5C);
        enc_case("f6",  6'd6,  4'h0, 3'd2, 3'd0, 3'd0, 11'h033, 16'h4A33);
        enc_case("f7",  6'd7,  4'h3, 3'd2, 3'd1, 3'd6, 11'h000, 16'h5D8A);
        enc_case("f9",  6'd9,  4'h1, 3'd5, 3'd4, 3'd0, 11'h00A, 16'h6AA5);
        enc_case("f10", 6'd10, 4'h1, 3'd0, 3'd6, 3'd0, 11'h003, 16'h88F0);
        enc_case("f11", 6'd11, 4'h0, 3'd5, 3'd0, 3'd0, 11'h010, 16'h9510);
        enc_case("f12", 6'd12, 4'h1, 3'd7, 3'd0, 3'd0, 11'h080, 16'hAF80);
        enc_case("f16", 6'd16, 4'h1, 3'd0, 3'd0, 3'd0, 11'h7FE, 16'hD1FE);

        // Illegal requests back to back
        set_req(6'd16, 4'hE, 3'd0, 3'd0, 3'd0, 11'h000);
        tick;
        check("ill1_err_fmt", 16'(err_fmt), 16'd1);
        check("ill1_err_count", 16'(err_count), 16'd1);
        check("ill1_out_valid", 16'(bus.out_valid), 16'd0);
        set_req(6'd1, 4'h3, 3'd1, 3'd1, 3'd0, 11'h001);
        tick;
        check("ill2_err_fmt", 16'(err_fmt), 16'd1);
        check("ill2_out_valid", 16'(bus.out_valid), 16'd0);
        set_req(6'd5, 4'h0, 3'd0, 3'd0, 3'd0, 11'h000);
        tick;
        bus.in_valid = 1'b0;
        check("ill3_err_fmt", 16'(err_fmt), 16'd1);
        check("ill3_err_count", 16'(err_count), 16'd3);
        check("ill3_out_valid", 16'(bus.out_valid), 16'd0);
        tick;
        check("ill_err_fmt_low", 16'(err_fmt), 16'd0);
        check("ill_level", 16'(level), 16'd0);
        $display("illegal x3 -> err_count=%0d", err_count);

        // Fill and drain
        for (int i = 0; i < 4; i++) begin
            set_req(6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h0A0 + 11'(i));
            tick;
            check("fill_level", 16'(level), 16'(i + 1));
        end
        check("full_in_ready", 16'(bus.in_ready), 16'd0);
        set_req(6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h555);
        tick;
        check("full_reject_level", 16'(level), 16'd4);
        set_req(6'd0, 4'h0, 3'd0, 3'd0, 3'd0, 11'h000);
        tick;
        bus.in_valid = 1'b0;
        check("full_ill_err_fmt", 16'(err_fmt), 16'd0);
        check("full_ill_err_count", 16'(err_count), 16'd3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 16'(bus.out_valid), 16'd1);
            check("drain_word", bus.out_instr, 16'hE0A0 + 16'(i));
            $display("drain pop %0d -> %h", i, bus.out_instr);
            tick;
            check("drain_level", 16'(level), 16'(3 - i));
            if (i == 0)
                check("drain_in_ready", 16'(bus.in_ready), 16'd1);
        end
        check("drain_empty", 16'(bus.out_valid), 16'd0);
        bus.out_ready = 1'b0;

        // Streaming with two words preloaded, across pointer wrap
        for (int k = 0; k < 2; k++) begin
            set_req(6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h100 + 11'(k));
            tick;
            exp_q.push_back(16'hE100 + 16'(k));
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < 22; k++) begin
            set_req(6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h100 + 11'(k));
            check("stream_valid", 16'(bus.out_valid), 16'd1);
            check("stream_word", bus.out_instr, exp_q[0]);
            $display("stream pop -> %h", bus.out_instr);
            tick;
            void'(exp_q.pop_front());
            exp_q.push_back(16'hE100 + 16'(k));
            check("stream_level", 16'(level), 16'd2);
        end
        bus.in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            check("stream_tail_word", bus.out_instr, exp_q[0]);
            $display("stream pop -> %h", bus.out_instr);
            tick;
            void'(exp_q.pop_front());
        end
        check("stream_empty", 16'(bus.out_valid), 16'd0);
        bus.out_ready = 1'b0;

        // Reset mid-operation with three words queued
        for (int k = 0; k < 3; k++) begin
            set_req(6'd18, 4'h0, 3'd0, 3'd0, 3'd0, 11'h200 + 11'(k));
            tick;
        end
        bus.in_valid = 1'b0;
        check("pre_rst_level", 16'(level), 16'd3);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("mid_rst_level", 16'(level), 16'd0);
        check("mid_rst_out_instr", bus.out_instr, 16'h0000);
        check("mid_rst_err_count", 16'(err_count), 16'd0);
        rst_n = 1'b1;
        #1;
        set_req(6'd3, 4'h1, 3'd0, 3'd0, 3'd0, 11'h00F);
        tick;
        bus.in_valid = 1'b0;
        check("post_rst_valid", 16'(bus.out_valid), 16'd1);
        check("post_rst_word", bus.out_instr, 16'h280F);
        check("post_rst_level", 16'(level), 16'd1);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("post_rst_empty", 16'(bus.out_valid), 16'd0);
        $display("reset recovery word -> %h", bus.out_instr);

        // Error counter saturation
        set_req(6'd0, 4'h0, 3'd0, 3'd0, 3'd0, 11'h000);
        for (int k = 0; k < 254; k++)
            tick;
        check("sat_254", 16'(err_count), 16'd254);
        tick;
        check("sat_255", 16'(err_count), 16'd255);
        for (int k = 0; k < 5; k++)
            tick;
        bus.in_valid = 1'b0;
        check("sat_hold", 16'(err_count), 16'd255);
        check("sat_err_fmt", 16'(err_fmt), 16'd1);
        check("sat_out_valid", 16'(bus.out_valid), 16'd0);
        tick;
        check("sat_err_fmt_low", 16'(err_fmt), 16'd0);
        check("sat_hold_after", 16'(err_count), 16'd255);
        $display("saturation -> err_count=%0d", err_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
